// File: rtl/mux_pkg.sv
// Shared definitions for the 3:1 mux family: select encodings, default data
// width and small index helpers.
package mux_pkg;

   localparam int WIDTH_DEFAULT = 3;

   typedef enum logic [1:0] {
      SEL_D0 = 2'd0,
      SEL_D1 = 2'd1,
      SEL_D2 = 2'd2
   } sel_e;

   // Successor of a select index in mod-3 rotation.
   function automatic sel_e next_sel(input sel_e v);
      case (v)
         SEL_D0:  return SEL_D1;
         SEL_D1:  return SEL_D2;
         default: return SEL_D0;
      endcase
   endfunction

   // One-hot request/grant bit for a select index.
   function automatic logic [2:0] sel_onehot(input sel_e v);
      case (v)
         SEL_D0:  return 3'b001;
         SEL_D1:  return 3'b010;
         SEL_D2:  return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/rr_pick_3.sv
// Combinational round-robin picker: the highest-priority requester in the
// order ptr+1, ptr+2, ptr wins.
module rr_pick_3
   import mux_pkg::*;
(
   input  logic [2:0] req,
   input  sel_e       ptr,
   output logic [2:0] gnt,
   output sel_e       idx
);

   sel_e c1_s;
   sel_e c2_s;

   assign c1_s = next_sel(ptr);
   assign c2_s = next_sel(c1_s);

   // Priority scan starting just after the last granted index.
   always_comb begin
      gnt = 3'b000;
      idx = ptr;
      if (|(req & sel_onehot(c1_s))) begin
         gnt = sel_onehot(c1_s);
         idx = c1_s;
      end else if (|(req & sel_onehot(c2_s))) begin
         gnt = sel_onehot(c2_s);
         idx = c2_s;
      end else if (|(req & sel_onehot(ptr))) begin
         gnt = sel_onehot(ptr);
         idx = ptr;
      end else begin
         gnt = 3'b000;
         idx = ptr;
      end
   end

endmodule

// File: rtl/rr_mux_3_1.sv
// Round-robin 3:1 mux with a single registered output stage and valid/ready
// handshake; back-pressure stalls all sources.
module rr_mux_3_1
   import mux_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       req,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   output logic [2:0]       gnt,
   output logic [1:0]       s,
   output logic [WIDTH-1:0] y,
   output logic             y_valid,
   input  logic             y_ready
);

   logic             advance_s;
   logic [2:0]       pick_gnt_s;
   sel_e             pick_idx_s;
   logic [WIDTH-1:0] d_sel_s;

   logic [WIDTH-1:0] y_q, y_d;
   sel_e             s_q, s_d;
   sel_e             ptr_q, ptr_d;
   logic             vld_q, vld_d;

   rr_pick_3 u_pick (
      .req (req),
      .ptr (ptr_q),
      .gnt (pick_gnt_s),
      .idx (pick_idx_s)
   );

   assign advance_s = !vld_q || y_ready;
   // Grant is also masked while reset is held so no source is consumed then.
   assign gnt       = (advance_s && rst_n) ? pick_gnt_s : 3'b000;

   // Data select for the winning source.
   always_comb begin
      d_sel_s = d0;
      case (pick_idx_s)
         SEL_D0:  d_sel_s = d0;
         SEL_D1:  d_sel_s = d1;
         SEL_D2:  d_sel_s = d2;
         default: d_sel_s = d0;
      endcase
   end

   // Next state of the output stage: load on grant, drain when idle, hold on stall.
   always_comb begin
      y_d   = y_q;
      s_d   = s_q;
      ptr_d = ptr_q;
      vld_d = vld_q;
      if (advance_s) begin
         if (|pick_gnt_s) begin
            y_d   = d_sel_s;
            s_d   = pick_idx_s;
            ptr_d = pick_idx_s;
            vld_d = 1'b1;
         end else begin
            vld_d = 1'b0;
         end
      end else begin
         vld_d = vld_q;
      end
   end

   // Output stage and rotation pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q   <= {WIDTH{1'b0}};
         s_q   <= SEL_D0;
         ptr_q <= SEL_D2;
         vld_q <= 1'b0;
      end else begin
         y_q   <= y_d;
         s_q   <= s_d;
         ptr_q <= ptr_d;
         vld_q <= vld_d;
      end
   end

   assign y       = y_q;
   assign s       = s_q;
   assign y_valid = vld_q;

endmodule

// File: doc/rr_mux_3_1.md
RR_MUX_3_1 -- requirements
Module: rr_mux_3_1

Interface
REQ-001 Parameter WIDTH, default 3, data width of each source and of y.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  3  per-source valid; bit i qualifies di.
REQ-005 d0, d1, d2  input  WIDTH each  source data.
REQ-006 gnt  output  3  one-hot combinational acknowledge; source i is consumed in the cycle gnt[i]=1.
REQ-007 s  output  2  registered index of the source currently held in y; encoding 0/1/2, value 3 never driven.
REQ-008 y  output  WIDTH  registered selected data.
REQ-009 y_valid  output  1  y holds unconsumed data.
REQ-010 y_ready  input  1  downstream accepts y when y_valid=1 and y_ready=1.

Function
REQ-011 The block SHALL compute advance = !y_valid || y_ready every cycle.
REQ-012 Priority order SHALL be ptr+1, ptr+2, ptr (mod 3), where ptr is the last granted index.
REQ-013 When advance=1 and req!=0, the block SHALL assert exactly one gnt bit for the highest-priority requester, else gnt=3'b000.
REQ-014 On a grant of index k: next edge y<=dk, s<=k, ptr<=k, y_valid<=1 (latency 1 cycle, req to y_valid).
REQ-015 When advance=1 and req=0, y_valid SHALL clear on the next edge; y and s SHALL hold.
REQ-016 When advance=0, y, s, y_valid, and ptr SHALL hold and gnt SHALL be 0 (back-pressure stalls all sources).
REQ-017 Simultaneous consume and grant (y_valid=1, y_ready=1, req!=0) SHALL reload y in the same edge with no bubble; full throughput is one item per cycle.
REQ-018 With a single persistent requester, that source SHALL be granted every advancing cycle.
REQ-019 With all three requesting and y_ready=1, grants SHALL rotate 0,1,2,0,... with no source starved beyond 2 intervening grants.
REQ-020 Data changes on a non-granted source SHALL NOT affect y.

Reset
REQ-021 While rst_n=0: y=0, s=2'd0, y_valid=0, ptr=2'd2 (so index 0 has first priority), gnt=0.
REQ-022 Reset assertion mid-operation SHALL discard held data immediately, without waiting for clk.
REQ-023 The first rising edge after rst_n deasserts SHALL be able to grant.

Structure
REQ-024 Shared package mux_pkg SHALL hold the select encodings SEL_D0=0, SEL_D1=1, SEL_D2=2 and the default WIDTH, and SHALL be reused by the 3:1 mux blocks.
REQ-025 Priority selection SHALL be a combinational sub-module rr_pick_3 (inputs req and ptr; outputs one-hot gnt and index).
REQ-026 Output register, ptr, and y_valid SHALL reside in rr_mux_3_1.

Verification
REQ-027 Reset check: d0=000, d1=001, d2=010, req=111, rst_n=0 -> y=000, s=0, y_valid=0, gnt=000; release, y_ready=1 -> s sequence 0,1,2,0 and y sequence 000,001,010,000 on consecutive cycles.
REQ-028 Single requester: req=100, d2=101, y_ready=1 -> gnt=100 every cycle, y=101, s=2, y_valid held at 1.
REQ-029 Back-pressure: req=111, y_ready=0 for 5 cycles after the first load -> y, s, and y_valid frozen and gnt=000; y_ready=1 -> rotation resumes from ptr+1.
REQ-030 Idle drain: y_valid=1, req=000, y_ready=1 -> y_valid=0 the next cycle, y unchanged.
REQ-031 Async reset mid-stream: rst_n pulsed low between clock edges while y_valid=1 -> y_valid=0 and y=0 before the next edge; the next grant goes to index 0.
REQ-032 Randomized long run with a scoreboard: every granted item appears exactly once on y in grant order, s always in {0,1,2}, and gnt is always one-hot or zero.
